// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter/receiver pair: FSM encodings,
// line levels and a constant-evaluable clog2 for sizing counters.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dff.sv
// Plain D flip-flop cell with no reset; callers gate reset into D.
module dff (
    input  logic clk,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register built from dff cells; shifts right with zero
// fill, exposes bit 0. Load has priority over shift; reset clears every bit.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] bits_reg;
    logic [WIDTH-1:0] bits_next;
    logic [WIDTH-1:0] bits_d;
    logic [WIDTH:0]   shift_src;

    assign shift_src = {1'b0, bits_reg};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bits_next[gi] = load  ? par_in[gi] :
                                   shift ? shift_src[gi+1] :
                                           bits_reg[gi];
            assign bits_d[gi] = bits_next[gi] & ~rst;
            dff u_cell (.clk(clk), .d(bits_d[gi]), .q(bits_reg[gi]));
        end
    endgenerate

    assign ser_out = bits_reg[0];

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, stop bit, each held
// CLKS_PER_BIT clocks. All state lives in dff cells with reset gated into D.
module serial_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx_out,
    output logic             busy
);

    localparam int TW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam int IW = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] INDEX_LAST = IW'(WIDTH - 1);

    logic [1:0]    state_reg;
    logic [1:0]    state_d;
    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;
    logic [TW-1:0] timer_d;
    logic [IW-1:0] index_reg;
    logic [IW-1:0] index_next;
    logic [IW-1:0] index_d;
    logic          tx_reg;
    logic          tx_next;
    logic          tx_d;
    logic          ready_reg;
    logic          ready_next;
    logic          ready_d;
    logic          load;
    logic          shift;
    logic          bit_done;
    logic          sr_bit0;

    assign state    = state_t'(state_reg);
    assign bit_done = (timer_reg == TIMER_LAST);

    // Next-state logic. The shift register advances on the same edge that the
    // line register captures its bit 0, so sr_bit0 always holds the next bit.
    always_comb begin
        state_next = state;
        timer_next = timer_reg;
        index_next = index_reg;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    load       = 1'b1;
                    timer_next = '0;
                    index_next = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    timer_next = '0;
                    shift      = 1'b1;
                    state_next = DATA;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_next = '0;
                    if (index_reg == INDEX_LAST) begin
                        state_next = STOP;
                    end else begin
                        index_next = index_reg + IW'(1);
                        shift      = 1'b1;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    timer_next = '0;
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state.
    always_comb begin
        tx_next    = tx_reg;
        ready_next = 1'b0;
        case (state_next)
            IDLE: begin
                tx_next    = LINE_IDLE;
                ready_next = 1'b1;
            end
            START: tx_next = START_BIT;
            DATA: begin
                if (shift) begin
                    tx_next = sr_bit0;
                end
            end
            STOP:    tx_next = STOP_BIT;
            default: tx_next = LINE_IDLE;
        endcase
    end

    assign state_d = state_next & {2{~rst}};
    assign timer_d = timer_next & {TW{~rst}};
    assign index_d = index_next & {IW{~rst}};
    assign tx_d    = tx_next | rst;
    assign ready_d = ready_next | rst;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_state
            dff u_cell (.clk(clk), .d(state_d[gi]), .q(state_reg[gi]));
        end
        for (gi = 0; gi < TW; gi++) begin : g_timer
            dff u_cell (.clk(clk), .d(timer_d[gi]), .q(timer_reg[gi]));
        end
        for (gi = 0; gi < IW; gi++) begin : g_index
            dff u_cell (.clk(clk), .d(index_d[gi]), .q(index_reg[gi]));
        end
    endgenerate

    dff u_tx    (.clk(clk), .d(tx_d),    .q(tx_reg));
    dff u_ready (.clk(clk), .d(ready_d), .q(ready_reg));

    piso_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .shift   (shift),
        .par_in  (data_in),
        .ser_out (sr_bit0)
    );

    assign tx_out    = tx_reg;
    assign ready_out = ready_reg;
    assign busy      = ~ready_reg;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-clock instance for the main
// scenarios and a 1-bit/1-clock instance for the degenerate timing corner.
module tb_serial_tx;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int N  = (W + 2) * C;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx_out;
    logic       busy;

    logic [0:0] c_data_in;
    logic       c_valid_in;
    logic       c_ready_out;
    logic       c_tx_out;
    logic       c_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .tx_out(tx_out), .busy(busy)
    );

    serial_tx #(.WIDTH(1), .CLKS_PER_BIT(1)) dut_c (
        .clk(clk), .rst(rst), .data_in(c_data_in), .valid_in(c_valid_in),
        .ready_out(c_ready_out), .tx_out(c_tx_out), .busy(c_busy)
    );

    // Expected line level c clocks after the accepting edge.
    function automatic logic exp_line(input logic [7:0] d, input int c, input int w, input int cpb);
        int b;
        b = c / cpb;
        if (b == 0) return 1'b0;
        if (b <= w) return d[b-1];
        return 1'b1;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_ready: ready_out=%b required 1 within 200 cycles", name, ready_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b1; data_in = 8'hFF;
        c_valid_in = 1'b1; c_data_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({tx_out, ready_out, busy} !== 3'b110) begin
                errors++;
                $display("FAIL reset_hold[%0d]: tx/ready/busy=%b required 110", i, {tx_out, ready_out, busy});
            end
            checks++;
            if ({c_tx_out, c_ready_out, c_busy} !== 3'b110) begin
                errors++;
                $display("FAIL reset_hold_corner[%0d]: tx/ready/busy=%b required 110", i, {c_tx_out, c_ready_out, c_busy});
            end
        end
        rst = 1'b0; c_valid_in = 1'b0;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_out, ready_out, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_accept: tx/ready/busy=%b required 001", {tx_out, ready_out, busy});
        end
        wait_ready("reset");
    endtask

    task automatic test_single_frame();
        data_in = 8'hA5; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0; data_in = 8'h00;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== exp_line(8'hA5, c, W, C) || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL single_frame[%0d]: tx=%b ready=%b required tx=%b ready=0", c, tx_out, ready_out, exp_line(8'hA5, c, W, C));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if ({tx_out, ready_out, busy} !== 3'b110) begin
            errors++;
            $display("FAIL single_frame_end: tx/ready/busy=%b required 110", {tx_out, ready_out, busy});
        end
    endtask

    task automatic test_back_to_back();
        wait_ready("b2b");
        data_in = 8'h00; valid_in = 1'b1;
        @(posedge clk);
        #1 data_in = 8'hFF;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== exp_line(8'h00, c, W, C) || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL b2b_frame1[%0d]: tx=%b ready=%b required tx=%b ready=0", c, tx_out, ready_out, exp_line(8'h00, c, W, C));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if ({tx_out, ready_out} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_ready_return: tx/ready=%b required 11", {tx_out, ready_out});
        end
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== exp_line(8'hFF, c, W, C) || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL b2b_frame2[%0d]: tx=%b ready=%b required tx=%b ready=0", c, tx_out, ready_out, exp_line(8'hFF, c, W, C));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: ready=%b required 1", ready_out);
        end
    endtask

    task automatic test_ignored_input();
        wait_ready("ignored");
        data_in = 8'hA5; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== exp_line(8'hA5, c, W, C) || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL ignored_input[%0d]: tx=%b ready=%b required tx=%b ready=0", c, tx_out, ready_out, exp_line(8'hA5, c, W, C));
            end
            if (c == 10) begin
                data_in = 8'h3C; valid_in = 1'b1;
            end else if (c == 11) begin
                valid_in = 1'b0;
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL ignored_end: ready=%b required 1", ready_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        wait_ready("midreset");
        data_in = 8'hA5; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== exp_line(8'hA5, c, W, C)) begin
                errors++;
                $display("FAIL midreset_pre[%0d]: tx=%b required %b", c, tx_out, exp_line(8'hA5, c, W, C));
            end
            if (c < 17) @(posedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tx_out, ready_out, busy} !== 3'b110) begin
            errors++;
            $display("FAIL midreset_line: tx/ready/busy=%b required 110", {tx_out, ready_out, busy});
        end
        rst = 1'b0;
        data_in = 8'h81; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            checks++;
            if (tx_out !== exp_line(8'h81, c, W, C) || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL midreset_new[%0d]: tx=%b ready=%b required tx=%b ready=0", c, tx_out, ready_out, exp_line(8'h81, c, W, C));
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL midreset_end: ready=%b required 1", ready_out);
        end
    endtask

    task automatic test_corner_params();
        logic [7:0] d;
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'h01 : 8'h00;
            c_data_in = d[0]; c_valid_in = 1'b1;
            @(posedge clk);
            #1 c_valid_in = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                checks++;
                if (c_tx_out !== exp_line(d, c, 1, 1) || c_ready_out !== 1'b0) begin
                    errors++;
                    $display("FAIL corner[%0d][%0d]: tx=%b ready=%b required tx=%b ready=0", f, c, c_tx_out, c_ready_out, exp_line(d, c, 1, 1));
                end
                @(posedge clk);
            end
            @(negedge clk);
            checks++;
            if ({c_tx_out, c_ready_out, c_busy} !== 3'b110) begin
                errors++;
                $display("FAIL corner_end[%0d]: tx/ready/busy=%b required 110", f, {c_tx_out, c_ready_out, c_busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_input();
        test_reset_mid_frame();
        test_corner_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
